// File: rtl/gcd_pkg.sv
// Shared definitions for the gcd engine and its lcm post-processing stage.
package gcd_pkg;

  localparam int gcd_width_p = 32;
  localparam int gcd_cnt_w_p = $clog2(gcd_width_p) + 1;

  typedef enum logic [2:0] {
    LCM_IDLE     = 3'd0,
    LCM_WAIT_GCD = 3'd1,
    LCM_DIV      = 3'd2,
    LCM_MUL      = 3'd3,
    LCM_DONE     = 3'd4
  } lcm_state_t;

  typedef enum logic [1:0] {
    GCD_IDLE = 2'd0,
    GCD_RUN  = 2'd1,
    GCD_DONE = 2'd2
  } gcd_state_t;

endpackage

// File: rtl/gcd_lcm_div.sv
// Sequential restoring divider: one quotient bit per step, MSB first.
// done is asserted combinationally during the final step, so the quotient is complete after that edge.
module gcd_lcm_div
  import gcd_pkg::*;
#(
  parameter int WIDTH = gcd_width_p
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvsr;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] rem_diff;
  logic             fits;

  // Trial subtraction; the dividend shifts out of the quotient register as quotient bits shift in.
  always_comb begin
    rem_shift = {rem, quotient[WIDTH-1]};
    fits      = (rem_shift >= {1'b0, dvsr});
    rem_diff  = rem_shift[WIDTH-1:0] - dvsr;
  end

  assign done = step && (cnt == CNT_W'(WIDTH - 1));

  // Divider state: load has priority over step.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem      <= '0;
      dvsr     <= '0;
      quotient <= '0;
      cnt      <= '0;
    end else if (load) begin
      rem      <= '0;
      dvsr     <= divisor;
      quotient <= dividend;
      cnt      <= '0;
    end else if (step) begin
      rem      <= fits ? rem_diff : rem_shift[WIDTH-1:0];
      quotient <= {quotient[WIDTH-2:0], fits};
      cnt      <= cnt + CNT_W'(1);
    end else begin
      rem      <= rem;
      dvsr     <= dvsr;
      quotient <= quotient;
      cnt      <= cnt;
    end
  end

endmodule

// File: rtl/gcd_lcm.sv
// LCM stage behind the gcd engine: lcm = (a / gcd) * b via a restoring divider and shift-add multiplier.
module gcd_lcm
  import gcd_pkg::*;
#(
  parameter int WIDTH = gcd_width_p
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic               gcd_done,
  input  logic [WIDTH-1:0]   gcd_result,
  output logic [2*WIDTH-1:0] lcm,
  output logic               lcm_valid,
  output logic               zero_op,
  output logic               busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  lcm_state_t         state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   quotient;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [CNT_W-1:0]   cnt;
  logic               zero_flag;
  logic               div_load;
  logic               div_step;
  logic               div_done;

  // A start in the same cycle suppresses any divider activity for the aborted operation.
  always_comb begin
    div_load = 1'b0;
    div_step = 1'b0;
    if (!start) begin
      div_load = (state == LCM_WAIT_GCD) && gcd_done;
      div_step = (state == LCM_DIV);
    end else begin
      div_load = 1'b0;
      div_step = 1'b0;
    end
  end

  gcd_lcm_div #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .reset    (reset),
    .load     (div_load),
    .step     (div_step),
    .dividend (a_q),
    .divisor  (gcd_result),
    .quotient (quotient),
    .done     (div_done)
  );

  // Controller, multiplier and registered outputs; busy stays high through the lcm_valid cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LCM_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      mcand     <= '0;
      cnt       <= '0;
      zero_flag <= 1'b0;
      lcm       <= '0;
      lcm_valid <= 1'b0;
      zero_op   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      lcm_valid <= 1'b0;
      if (start) begin
        a_q       <= a_in;
        b_q       <= b_in;
        acc       <= '0;
        cnt       <= '0;
        lcm       <= '0;
        zero_op   <= 1'b0;
        busy      <= 1'b1;
        zero_flag <= (a_in == '0) || (b_in == '0);
        state     <= ((a_in == '0) || (b_in == '0)) ? LCM_DONE : LCM_WAIT_GCD;
      end else begin
        case (state)
          LCM_IDLE: begin
            busy <= 1'b0;
          end
          LCM_WAIT_GCD: begin
            if (gcd_done) begin
              cnt   <= '0;
              acc   <= '0;
              mcand <= {{WIDTH{1'b0}}, b_q};
              state <= LCM_DIV;
            end
          end
          LCM_DIV: begin
            if (div_done) begin
              state <= LCM_MUL;
            end
          end
          LCM_MUL: begin
            if (quotient[cnt[CNT_W-2:0]]) begin
              acc <= acc + mcand;
            end
            mcand <= mcand << 1;
            cnt   <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
              state <= LCM_DONE;
            end
          end
          LCM_DONE: begin
            lcm       <= acc;
            lcm_valid <= 1'b1;
            zero_op   <= zero_flag;
            state     <= LCM_IDLE;
          end
          default: begin
            state <= LCM_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/gcd_lcm.md
# gcd_lcm

Post-processing stage that sits directly downstream of the `gcd` engine and turns its result into the least common multiple of the same operand pair. It snoops the operand/start bus that feeds the engine, waits for the engine's `done`, then computes lcm = (a / gcd) * b. The quotient comes from a 32-cycle restoring divider and the product from a 32-cycle shift-add multiplier. It produces a 64-bit result with a one-cycle valid pulse.

## Interface
Parameters
- `WIDTH`, 32: operand and GCD width; the result is 2*WIDTH bits.

Ports
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  same pulse that drives the `gcd` engine's `start`; qualifies `a_in`/`b_in`.
- `a_in`  in  WIDTH  operand a, sampled when `start`=1.
- `b_in`  in  WIDTH  operand b, sampled when `start`=1.
- `gcd_done`  in  1  engine `done`.
- `gcd_result`  in  WIDTH  engine `result`, valid while `gcd_done`=1.
- `lcm`  out  2*WIDTH  LCM result; holds its value until the next `start` or `reset`.
- `lcm_valid`  out  1  one-cycle pulse when `lcm` is updated.
- `zero_op`  out  1  set with `lcm_valid` when either operand was 0; cleared on `start`.
- `busy`  out  1  high in every state except IDLE.

## Operation
States: IDLE, WAIT_GCD, DIV, MUL, DONE.
- **IDLE / any state, `start`=1:**
  - Capture a and b, clear `zero_op` and `lcm`.
  - If a==0 or b==0, go to DONE with lcm=0 and `zero_op`=1. The engine may never finish for a zero operand, so `gcd_done` is not awaited.
  - Otherwise go to WAIT_GCD.
- **WAIT_GCD:** on `gcd_done`=1, latch `gcd_result` as the divisor, clear the iteration counter, go to DIV. `gcd_done` in any other state is ignored.
- **DIV:**
  - One restoring-division step per cycle, MSB first, dividend a: remainder r = {r, a[i]}; if r >= g then subtract g and set q[i].
  - Runs exactly WIDTH iterations. The remainder is always 0, and is not checked.
- **MUL:**
  - One step per cycle, LSB first: if q[i], acc += b << i.
  - acc is 2*WIDTH bits and never overflows, since lcm <= a*b < 2^64.
  - After WIDTH steps, go to DONE.
- **DONE:** `lcm` = acc, `lcm_valid`=1 for this cycle only, then IDLE.
- **Start priority:** `start` has priority over everything, including `gcd_done` in the same cycle and mid-DIV/MUL. The operation in flight is aborted silently, with no `lcm_valid`.
- **Reset values:** all outputs 0, state IDLE, all datapath registers 0. Reset takes effect from any state, including mid-DIV/MUL.

## Timing
- **Normal path:** `gcd_done` sampled at edge E0.
  - DIV occupies edges E1..E32 and MUL occupies E33..E64.
  - `lcm`/`lcm_valid` are registered outputs, high in the cycle after edge E65.
  - Fixed latency: 65 cycles from `gcd_done` to `lcm_valid`, independent of operand values.
- **Zero-operand path:** `lcm_valid` rises one cycle after the `start` edge.
- **`busy`:** rises the cycle after `start`; falls the cycle after `lcm_valid`.
- **`lcm_valid`:** never high for two consecutive cycles.

## Structure
- **Shared package `gcd_pkg`** holds:
  - `gcd_width_p` = 32.
  - the `lcm_state_t` enum (IDLE, WAIT_GCD, DIV, MUL, DONE).
  - the iteration-counter width `$clog2(WIDTH)+1`.
  - The `gcd` engine's control FSM also moves its typedefs here.
- **Sub-module `gcd_lcm_div`:** the sequential restoring divider, with ports load/step/quotient/done. The controller FSM and the shift-add multiplier remain in `gcd_lcm`.

## Test plan
- **Basic:** a=12, b=18, `gcd_done` with `gcd_result`=6 → `lcm`=36, `lcm_valid` exactly 65 cycles after `gcd_done`, `zero_op`=0.
- **Coprime, full width:** a=0xFFFFFFFF, b=0xFFFFFFFE, `gcd_result`=1 → `lcm`=0xFFFFFFFD_00000002.
- **Zero operand:** a=0, b=5 → `lcm`=0 and `zero_op`=1 one cycle after `start`; a later `gcd_done` is ignored and no second `lcm_valid` occurs.
- **Equal operands:** a=b=7, `gcd_result`=7 → `lcm`=7.
- **Restart mid-MUL:** a=4, b=6; new `start` with a=5, b=3 during MUL → no pulse for the first pair; `lcm`=15 after its `gcd_done`.
- **Reset mid-DIV:** assert `reset` for 1 cycle during DIV → next cycle all outputs 0, `busy`=0, state IDLE; a subsequent a=12, b=18 run yields 36.
